// File: rtl/envelope_gen_if.sv
// Voice control inputs and envelope outputs of envelope_gen.
// Master drives gates, notes and rates; slave returns levels.
interface envelope_gen_if;
  logic [7:0]       gate_in;
  logic [7:0][2:0]  velocity_in;
  logic [7:0][6:0]  note_in;
  logic [15:0]      attack_rate;
  logic [15:0]      decay_rate;
  logic [15:0]      release_rate;
  logic [7:0]       sustain_level;
  logic [7:0][15:0] env_out;
  logic [7:0]       voice_active;
  logic             sample_valid;

  modport master (
    output gate_in,
    output velocity_in,
    output note_in,
    output attack_rate,
    output decay_rate,
    output release_rate,
    output sustain_level,
    input  env_out,
    input  voice_active,
    input  sample_valid
  );

  modport slave (
    input  gate_in,
    input  velocity_in,
    input  note_in,
    input  attack_rate,
    input  decay_rate,
    input  release_rate,
    input  sustain_level,
    output env_out,
    output voice_active,
    output sample_valid
  );
endinterface

// File: rtl/envelope_gen.sv
// 8-voice ADSR envelope generator, one voice updated per cycle after each tick.
// Define ENV_VEL_SCALE_EN to scale each voice's peak by its latched velocity.
module envelope_gen #(
  parameter int unsigned SAMPLE_DIV = 3200
) (
  input logic           clk,
  input logic           rst_n,
  envelope_gen_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTACK,
    S_DECAY,
    S_SUSTAIN,
    S_RELEASE
  } vstate_t;

  typedef enum logic [1:0] {
    SW_WAIT,
    SW_RUN,
    SW_FLAG
  } sweep_t;

  localparam logic [15:0] DivLast = 16'(SAMPLE_DIV - 1);

  logic [15:0] r_tick_cnt;
  logic [2:0]  r_slot;
  sweep_t      r_sw;
  sweep_t      w_sw_nxt;
  logic        r_sample_valid;
  logic        w_tick;
  logic        w_upd;
  logic        w_sv_set;

  vstate_t     r_state     [8];
  logic [15:0] r_level     [8];
  logic [6:0]  r_note_prev [8];
  logic [7:0]  r_gate_prev;

  assign w_tick = (r_tick_cnt == DivLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw           <= SW_WAIT;
      r_slot         <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sw           <= w_sw_nxt;
      r_slot         <= (r_sw == SW_RUN) ? r_slot + 3'd1 : 3'd0;
      r_sample_valid <= w_sv_set;
    end
  end

  always_comb begin
    w_sw_nxt = r_sw;
    w_upd    = 1'b0;
    w_sv_set = 1'b0;
    unique case (r_sw)
      SW_WAIT: begin
        if (w_tick) w_sw_nxt = SW_RUN;
      end
      SW_RUN: begin
        w_upd = 1'b1;
        if (r_slot == 3'd7) w_sw_nxt = SW_FLAG;
      end
      SW_FLAG: begin
        w_sv_set = 1'b1;
        w_sw_nxt = SW_WAIT;
      end
      default: w_sw_nxt = SW_WAIT;
    endcase
  end

  logic        w_gate;
  logic [6:0]  w_note;
  logic        w_trig;
  logic        w_rel;
  vstate_t     w_cur;
  vstate_t     w_st;
  vstate_t     w_ns;
  logic [15:0] w_lvl;
  logic [15:0] w_nl;
  logic [15:0] w_peak;
  logic [15:0] w_sus;
  logic [15:0] w_ar;
  logic [15:0] w_dr;
  logic [15:0] w_rr;
  logic [16:0] w_sum;
  logic [16:0] w_dec_floor;

  assign w_gate = bus.gate_in[r_slot];
  assign w_note = bus.note_in[r_slot];
  assign w_cur  = r_state[r_slot];
  assign w_lvl  = r_level[r_slot];
  assign w_ar   = bus.attack_rate;
  assign w_dr   = bus.decay_rate;
  assign w_rr   = bus.release_rate;

  assign w_trig = w_gate &&
                  (!r_gate_prev[r_slot] ||
                   (w_note != r_note_prev[r_slot]));
  assign w_rel  = !w_gate &&
                  (w_cur inside {S_ATTACK, S_DECAY, S_SUSTAIN});

`ifdef ENV_VEL_SCALE_EN
  logic [2:0] r_vel [8];
  logic [2:0] w_vel;

  // ((v+1)<<13)-1 is v in the top bits over all-ones.
  assign w_vel  = w_trig ? bus.velocity_in[r_slot] : r_vel[r_slot];
  assign w_peak = {w_vel, 13'h1FFF};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) r_vel[k] <= '0;
    end else if (w_upd) begin
      r_vel[r_slot] <= w_vel;
    end
  end
`else
  logic w_unused_vel;

  assign w_unused_vel = ^bus.velocity_in;
  assign w_peak       = 16'hFFFF;
`endif

  assign w_sus = {8'h00, w_peak[15:8]} * {8'h00, bus.sustain_level};

  always_comb begin
    w_st = w_cur;
    if (w_trig) begin
      w_st = S_ATTACK;
    end else if (w_rel) begin
      w_st = S_RELEASE;
    end
  end

  always_comb begin
    w_ns        = w_st;
    w_nl        = w_lvl;
    w_sum       = {1'b0, w_lvl} + {1'b0, w_ar};
    w_dec_floor = {1'b0, w_sus} + {1'b0, w_dr};
    unique case (w_st)
      S_IDLE: begin
        w_nl = w_lvl;
      end
      S_ATTACK: begin
        if ((w_ar == '0) || (w_sum >= {1'b0, w_peak})) begin
          w_nl = w_peak;
          w_ns = S_DECAY;
          // Entering decay already at or under the floor skips it.
          if (w_sus >= w_peak) begin
            w_nl = w_sus;
            w_ns = S_SUSTAIN;
          end
        end else begin
          w_nl = w_sum[15:0];
        end
      end
      S_DECAY: begin
        if ((w_dr == '0) || ({1'b0, w_lvl} <= w_dec_floor)) begin
          w_nl = w_sus;
          w_ns = S_SUSTAIN;
        end else begin
          w_nl = w_lvl - w_dr;
        end
      end
      S_SUSTAIN: begin
        w_nl = w_sus;
      end
      S_RELEASE: begin
        if ((w_rr == '0) || (w_lvl <= w_rr)) begin
          w_nl = '0;
          w_ns = S_IDLE;
        end else begin
          w_nl = w_lvl - w_rr;
        end
      end
      default: begin
        w_nl = '0;
        w_ns = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        r_state[k]     <= S_IDLE;
        r_level[k]     <= '0;
        r_note_prev[k] <= '0;
      end
      r_gate_prev <= '0;
    end else if (w_upd) begin
      r_state[r_slot]     <= w_ns;
      r_level[r_slot]     <= w_nl;
      r_note_prev[r_slot] <= w_note;
      r_gate_prev[r_slot] <= w_gate;
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_out
    assign bus.env_out[k]      = r_level[k];
    assign bus.voice_active[k] = (r_state[k] != S_IDLE);
  end

  assign bus.sample_valid = r_sample_valid;

endmodule

// File: doc/envelope_gen.md
ENVELOPE_GEN -- requirements
Module: envelope_gen

Interface
REQ-001 Parameter SAMPLE_DIV, default 3200, clock cycles per envelope sample tick; legal range 16..65535.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 gate_in  input  [7:0]  per-voice note-active flags from the MIDI receiver.
REQ-005 velocity_in  input  [7:0][2:0]  per-voice 3-bit velocity.
REQ-006 note_in  input  [7:0][6:0]  per-voice note number, used only for retrigger detection.
REQ-007 attack_rate, decay_rate, release_rate  input  16 each  level step per sample tick.
REQ-008 sustain_level  input  8  sustain fraction of peak, 0..255.
REQ-009 env_out  output  [7:0][15:0]  per-voice envelope level, unsigned.
REQ-010 voice_active  output  [7:0]  1 while voice state is not IDLE.
REQ-011 sample_valid  output  1  one-cycle pulse when all 8 env_out values are updated for the tick.

Function
REQ-012 Tick counter counts 0..SAMPLE_DIV-1 and wraps; a tick fires when it equals SAMPLE_DIV-1.
REQ-013 Voices are updated time-multiplexed: voice k is updated on cycle k+1 after the tick (k=0..7), one voice per cycle.
REQ-014 sample_valid pulses on the cycle after voice 7 is updated (cycle 9 after the tick).
REQ-015 Each voice has states IDLE, ATTACK, DECAY, SUSTAIN, RELEASE, plus registered gate_prev and note_prev. Gate and note inputs are sampled only in the voice's own slot.
REQ-016 Trigger: gate rises (gate_in=1, gate_prev=0), or gate_in=1 with note_in differing from note_prev. A trigger enters ATTACK from any state, starting at the current level with no reset to 0.
REQ-017 Release: gate_in=0 in ATTACK, DECAY or SUSTAIN enters RELEASE in the same slot.
REQ-018 Peak = ((velocity+1)<<13)-1, with velocity latched at trigger; sustain target = (peak>>8)*sustain_level.
REQ-019 ATTACK: level += attack_rate, saturating at peak; on reaching peak, go to DECAY.
REQ-020 DECAY: level -= decay_rate, clamped at sustain target; on reaching it, go to SUSTAIN.
REQ-021 SUSTAIN: level holds at the sustain target.
REQ-022 RELEASE: level -= release_rate, clamped at 0; on reaching 0, go to IDLE.
REQ-023 A rate of 0 means instant: the level jumps to the stage target in one slot.
REQ-024 Arithmetic uses 17-bit intermediates; no wrap-around is permitted.
REQ-025 If sustain target >= current level on DECAY entry, the voice goes directly to SUSTAIN at the target.
REQ-026 Trigger and release tests are evaluated before stage arithmetic; a stage transition takes effect within the same slot.
REQ-027 Rate and sustain inputs are sampled per slot; a change mid-envelope applies from the next slot.

Reset
REQ-028 On rst_n=0, asynchronously: env_out=0, voice_active=0, sample_valid=0, all states IDLE, gate_prev=0, note_prev=0, tick and slot counters 0.
REQ-029 Reset asserted mid-sweep aborts the sweep; after release, the first tick is SAMPLE_DIV cycles later.

Configuration
REQ-030 Macro ENV_VEL_SCALE_EN defined: peak follows REQ-018.
REQ-031 ENV_VEL_SCALE_EN undefined: peak = 16'hFFFF for every voice, velocity_in is ignored, and all other behaviour is identical.

Verification
REQ-032 Gate0 high, velocity 7, attack_rate 0x1000, decay_rate 0x0800, sustain_level 128, release 0x0400: env_out[0] rises 0x1000 per tick, peaks at 0xFFFF on tick 16, then decays to 0x7F80 and holds.
REQ-033 In SUSTAIN, drop gate0: env_out[0] falls 0x0400 per tick, reaches 0 with voice_active[0]=0 after 32 ticks.
REQ-034 With ENV_VEL_SCALE_EN, velocity 0, attack_rate 0: env_out reaches peak 0x1FFF in one tick.
REQ-035 Voice 3 in RELEASE at 0x4000, gate rises again: ATTACK resumes from 0x4000, not 0.
REQ-036 Gate held high while note_in[2] changes 60->64 between ticks: voice 2 retriggers into ATTACK.
REQ-037 Assert rst_n low mid-sweep (slot 4): all outputs 0 immediately; sample_valid absent until the first full post-reset sweep.
